// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB first, with repeats and idle gaps
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       st
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_r, pat_n;
    logic [PAT_W-1:0] sh_r, sh_n;
    logic [GAP_W-1:0] gap_r, gap_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [IDX_W-1:0] bit_idx, bit_idx_n;
    logic [CNT_W-1:0] reps_left, reps_left_n;
    logic             x_n, valid_n, busy_n, done_n;

    assign st = state;

    // Outputs are computed for the next state and registered with it,
    // so x_out/bit_valid/busy/done always describe the state shown on st.
    always_comb begin
        state_n     = state;
        pat_n       = pat_r;
        sh_n        = sh_r;
        gap_n       = gap_r;
        gap_cnt_n   = gap_cnt;
        bit_idx_n   = bit_idx;
        reps_left_n = reps_left;
        x_n         = 1'b0;
        valid_n     = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = SHIFT;
                    pat_n       = pattern;
                    sh_n        = pattern;
                    gap_n       = gap_len;
                    bit_idx_n   = '0;
                    reps_left_n = repeat_cnt;
                    x_n         = pattern[PAT_W-1];
                    valid_n     = 1'b1;
                    busy_n      = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_idx != LAST_IDX) begin
                    bit_idx_n = bit_idx + 1'b1;
                    sh_n      = {sh_r[PAT_W-2:0], 1'b0};
                    x_n       = sh_r[PAT_W-2];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                end else if (reps_left == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (gap_r == '0) begin
                    reps_left_n = reps_left - 1'b1;
                    bit_idx_n   = '0;
                    sh_n        = pat_r;
                    x_n         = pat_r[PAT_W-1];
                    valid_n     = 1'b1;
                    busy_n      = 1'b1;
                end else begin
                    state_n     = GAP;
                    reps_left_n = reps_left - 1'b1;
                    gap_cnt_n   = gap_r;
                    busy_n      = 1'b1;
                end
            end
            GAP: begin
                busy_n = 1'b1;
                if (gap_cnt == GAP_W'(1)) begin
                    state_n   = SHIFT;
                    bit_idx_n = '0;
                    sh_n      = pat_r;
                    x_n       = pat_r[PAT_W-1];
                    valid_n   = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_r     <= '0;
            sh_r      <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            bit_idx   <= '0;
            reps_left <= '0;
            x_out     <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            pat_r     <= pat_n;
            sh_r      <= sh_n;
            gap_r     <= gap_n;
            gap_cnt   <= gap_cnt_n;
            bit_idx   <= bit_idx_n;
            reps_left <= reps_left_n;
            x_out     <= x_n;
            bit_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the generator side of the serial sequence detectors in this codebase. It captures a PAT_W-bit pattern and shifts it out MSB first, one bit per clock. The pattern is sent repeat_cnt+1 times, with an optional idle gap between repetitions. Its output drives detector inputs (e.g. the 1011 detectors) in system and bench use.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 4, width of repeat count
GAP_W, 3, width of inter-pattern gap length

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  pattern to send, MSB transmitted first
repeat_cnt  input  CNT_W  extra repetitions (total sends = repeat_cnt+1)
gap_len  input  GAP_W  idle cycles between repetitions (0 = back-to-back)
x_out  output  1  serial data bit (registered)
bit_valid  output  1  high when x_out carries a pattern bit (registered)
busy  output  1  high from first bit cycle through last bit cycle, including gaps
done  output  1  one-cycle pulse after final bit
st  output  2  current FSM state (debug)

Behaviour:
- Reset (async, rst_n=0): state IDLE, x_out=0, bit_valid=0, busy=0, done=0, st=0; internal counters cleared. Takes effect immediately mid-transfer; any partial pattern is abandoned with no done pulse.
- FSM encoding: IDLE=0, SHIFT=1, GAP=2, DONE=3. st always equals the current state.
- IDLE: outputs 0. On a clock edge with start=1: latch pattern, repeat_cnt and gap_len into shadow registers, set bit_idx=0, reps_left=repeat_cnt, go to SHIFT.
- SHIFT: in the cycle after the capture edge, x_out=pattern[PAT_W-1], bit_valid=1, busy=1. Each following cycle presents the next lower bit. At bit_idx=PAT_W-1 (LSB cycle):
  - reps_left=0 -> DONE.
  - Else if gap=0 -> stay in SHIFT; restart at the MSB next cycle; reps_left-1. No bubble between repetitions.
  - Else -> GAP; reps_left-1.
- GAP: exactly gap_len cycles with x_out=0, bit_valid=0, busy=1; then SHIFT at the MSB.
- DONE: done=1 and busy=0 for exactly one cycle, x_out=0, bit_valid=0; then IDLE.
- start in SHIFT, GAP or DONE is ignored and never queued. Changes on pattern, repeat_cnt or gap_len after capture have no effect.
- start=1 held continuously: a new transfer is captured on the first edge in IDLE. Minimum spacing between transfers is therefore one DONE cycle plus one IDLE cycle.
- Transfer length: busy is high for (R+1)*PAT_W + R*G cycles, where R=repeat_cnt and G=gap_len. Counters never wrap: R is at most 2^CNT_W-1 and G at most 2^GAP_W-1.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Single send: pattern=4'b1011, repeat_cnt=0, gap_len=0, start pulse -> x_out=1,0,1,1 with bit_valid=1 on cycles 1-4 after start; done=1 on cycle 5; busy high cycles 1-4; st sequence 1,1,1,1,3,0.
- Back-to-back: pattern=1011, repeat_cnt=2, gap_len=0 -> 12 contiguous valid bits 101110111011, done on cycle 13. A connected overlapping 1011 Mealy detector asserts y exactly 3 times.
- Gapped: pattern=1011, repeat_cnt=1, gap_len=2 -> valid 1011, two cycles bit_valid=0/x_out=0 with st=2, valid 1011, then done; busy high for 10 cycles.
- Ignored start/inputs: during the transfer above, pulse start and change pattern to 0000 -> stream unchanged, exactly one done pulse.
- Async reset mid-stream: drop rst_n during the 3rd bit -> x_out, bit_valid, busy and st go to 0 without a clock edge, and no done pulse. After release, start with pattern=0110 -> 0,1,1,0 then done.
- Maximum values: PAT_W=8, pattern=8'hA5, repeat_cnt=15, gap_len=7 -> 16 copies of 10100101, each separated by 7 idle cycles. Total busy is 233 cycles, then a single done pulse.
